// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one DIGIT-bit slice per clock, LSB first.
// Start/busy/done handshake; borrow ripples through an internal register between slices.
module serial_subtractor #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("serial_subtractor: DIGIT must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_brw;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic [DIGIT:0]   w_sub;
    logic             w_bo;
    logic [WIDTH-1:0] w_diff_next;

    assign w_accept = (r_state == StIdle) && start;
    assign w_last   = (r_cnt == CW'(N - 1));

    // Operand registers shift right each RUN cycle, so the active slice is always the LSBs.
    assign w_sub = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_b[DIGIT-1:0]} - {{DIGIT{1'b0}}, r_brw};
    assign w_bo  = w_sub[DIGIT];

    always_comb begin
        w_diff_next = r_diff;
        for (int unsigned i = 0; i < N; i++) begin
            if (r_cnt == CW'(i)) begin
                w_diff_next[i*DIGIT +: DIGIT] = w_sub[DIGIT-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (start) w_state_next = StRun;
            StRun:   if (w_last) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_brw    <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_brw <= bin;
            r_cnt <= '0;
        end else if (r_state == StRun) begin
            r_a    <= r_a >> DIGIT;
            r_b    <= r_b >> DIGIT;
            r_brw  <= w_bo;
            r_cnt  <= r_cnt + CW'(1);
            r_diff <= w_diff_next;
            // Flags only move on the final slice so they hold the previous result meanwhile.
            if (w_last) begin
                r_borrow <= w_bo;
                r_zero   <= (w_diff_next == '0);
            end
        end
    end

    assign busy   = (r_state == StRun);
    assign done   = (r_state == StDone);
    assign diff   = r_diff;
    assign borrow = r_borrow;
    assign zero   = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: a 16/4 instance and a bit-serial 8/1 instance,
// checked against plain integer arithmetic for a - b - bin.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start16;
    logic        start8;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;

    logic        busy16, done16, borrow16, zero16;
    logic [15:0] diff16;
    logic        busy8, done8, borrow8, zero8;
    logic [7:0]  diff8;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start16),
        .a      (a),
        .b      (b),
        .bin    (bin),
        .busy   (busy16),
        .done   (done16),
        .diff   (diff16),
        .borrow (borrow16),
        .zero   (zero16)
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .a      (a[7:0]),
        .b      (b[7:0]),
        .bin    (bin),
        .busy   (busy8),
        .done   (done8),
        .diff   (diff8),
        .borrow (borrow8),
        .zero   (zero8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation on the selected instance; inputs are scrambled after acceptance.
    task automatic run_op(input bit sel, input logic [15:0] ea, input logic [15:0] eb,
                          input logic ebin, input string tag);
        int          n;
        int          cyc;
        int          ia;
        int          ib;
        int          ibin;
        logic [15:0] mask;
        logic [15:0] exp_d;
        logic        exp_b;
        n     = sel ? 8 : 4;
        mask  = sel ? 16'h00FF : 16'hFFFF;
        ia    = int'(ea & mask);
        ib    = int'(eb & mask);
        ibin  = int'(ebin);
        exp_b = (ia < ib + ibin);
        exp_d = 16'(ia - ib - ibin) & mask;

        a   = ea;
        b   = eb;
        bin = ebin;
        if (sel) start8 = 1'b1;
        else     start16 = 1'b1;
        tick();
        start8  = 1'b0;
        start16 = 1'b0;
        a   = 16'($urandom);
        b   = 16'($urandom);
        bin = 1'($urandom);

        cyc = 0;
        while (!(sel ? done8 : done16) && cyc < 40) begin
            check({tag, ".busy"}, 32'(sel ? busy8 : busy16), 32'd1);
            tick();
            cyc++;
        end
        check({tag, ".cycles"}, 32'(cyc), 32'(n));
        check({tag, ".diff"}, 32'(sel ? {8'h00, diff8} : diff16), 32'(exp_d));
        check({tag, ".borrow"}, 32'(sel ? borrow8 : borrow16), 32'(exp_b));
        check({tag, ".zero"}, 32'(sel ? zero8 : zero16), 32'(exp_d == 16'h0));
        check({tag, ".busy_at_done"}, 32'(sel ? busy8 : busy16), 32'd0);
        tick();
        check({tag, ".done_pulse"}, 32'(sel ? done8 : done16), 32'd0);
        check({tag, ".diff_hold"}, 32'(sel ? {8'h00, diff8} : diff16), 32'(exp_d));
    endtask

    initial begin
        int cyc;
        rst_n   = 1'b0;
        start16 = 1'b0;
        start8  = 1'b0;
        a       = '0;
        b       = '0;
        bin     = 1'b0;

        #3;
        check("rst.busy16", 32'(busy16), 32'd0);
        check("rst.done16", 32'(done16), 32'd0);
        check("rst.diff16", 32'(diff16), 32'd0);
        check("rst.borrow16", 32'(borrow16), 32'd0);
        check("rst.zero16", 32'(zero16), 32'd0);
        check("rst.busy8", 32'(busy8), 32'd0);
        check("rst.diff8", 32'(diff8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_op(1'b0, 16'h1234, 16'h0234, 1'b0, "basic");
        run_op(1'b0, 16'h0000, 16'h0001, 1'b0, "ripple");
        run_op(1'b0, 16'h5A5A, 16'h5A5A, 1'b0, "equal");
        run_op(1'b0, 16'h5A5A, 16'h5A5A, 1'b1, "equal_bin");
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, "max_bin");
        for (int i = 0; i < 10; i++) begin
            run_op(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), "rand16");
        end

        // Start held through RUN/DONE must not be re-accepted before T0+N+2.
        a       = 16'h0010;
        b       = 16'h0001;
        bin     = 1'b0;
        start16 = 1'b1;
        tick();
        a = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            check("hold.busy", 32'(busy16), 32'd1);
            tick();
        end
        check("hold.done", 32'(done16), 32'd1);
        check("hold.diff", 32'(diff16), 32'h000F);
        tick();
        check("hold.idle_busy", 32'(busy16), 32'd0);
        check("hold.idle_done", 32'(done16), 32'd0);
        tick();
        check("hold.reaccept", 32'(busy16), 32'd1);
        start16 = 1'b0;
        cyc = 0;
        while (!done16 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("hold.cycles2", 32'(cyc), 32'd4);
        check("hold.diff2", 32'(diff16), 32'hFFFE);
        check("hold.borrow2", 32'(borrow16), 32'd0);
        tick();

        // Asynchronous reset two cycles into an operation.
        a       = 16'h1234;
        b       = 16'h4321;
        bin     = 1'b0;
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst.busy", 32'(busy16), 32'd0);
        check("midrst.done", 32'(done16), 32'd0);
        check("midrst.diff", 32'(diff16), 32'd0);
        check("midrst.borrow", 32'(borrow16), 32'd0);
        check("midrst.zero", 32'(zero16), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("midrst.no_done", 32'(done16), 32'd0);
        end
        rst_n = 1'b1;
        run_op(1'b0, 16'h0003, 16'h0001, 1'b0, "recover");

        run_op(1'b1, 16'h0080, 16'h0001, 1'b0, "bitser");
        run_op(1'b1, 16'h0000, 16'h0000, 1'b1, "bitser_bin");
        for (int i = 0; i < 5; i++) begin
            run_op(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), "rand8");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
